u_r_x: RTL and testbench
========================

# u_r_x

Serial receiver for the 8-bit, odd-parity, 1-stop-bit line format our serial transmitter produces. It sits between the external serial input pin and the design logic. It oversamples the line with a bit-period timer and samples each bit at mid-bit. It presents each received byte with a level-held valid/acknowledge handshake and per-frame parity, framing and overrun status.

## Interface
- CLKS_PER_BIT, default 5209: clock cycles per serial bit. Must be ≥ 4.
- HALF_BIT, default CLKS_PER_BIT/2 (2604): cycles from start-edge detection to the start-bit mid-point sample.
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- in_serial  input  1  asynchronous serial line. Idle high.
- rx_ack  input  1  consumer acknowledge of the current byte.
- rx_data  output  8  last received byte, bit 0 first on the line.
- rx_valid  output  1  rx_data and status flags are valid. Held until acknowledged.
- rx_parity_err  output  1  parity check failed for the byte in rx_data.
- rx_frame_err  output  1  stop bit sampled low for the byte in rx_data.
- rx_overrun  output  1  a frame completed while rx_valid was still high. Sticky.
- rx_busy  output  1  a frame is being received (state ≠ IDLE).

## Operation
- **Input synchronizer.** in_serial passes through 2 flops, both reset to 1. All logic uses the synchronized value s_in.
- **Timer.** A 13-bit counter clears on state entry and otherwise increments. tick_half asserts when count == HALF_BIT-1. tick_full asserts when count == CLKS_PER_BIT-1; on tick_full the counter also clears.
- **Bit counter.** 3 bits. Cleared on entering BITS. Incremented on each data sample except the last.
- **IDLE**
  - s_in==0 → START, timer cleared.
- **START**
  - On tick_half, sample s_in.
  - s_in==1 (glitch/false start) → IDLE.
  - s_in==0 → BITS, timer cleared.
- **BITS**
  - On each tick_full, shift s_in into a shift register, LSB first, so the first data bit lands in bit 0.
  - After the 8th sample (bit counter == 7) → PAR.
- **PAR**
  - On tick_full, capture parity bit p.
  - parity_bad = ~(^{data,p}), i.e. the total count of ones across data and p must be odd.
  - → STOP.
- **STOP**
  - On tick_full, sample the stop bit and → DONE.
- **DONE** (1 cycle)
  - Load rx_data ← shift register, rx_parity_err ← parity_bad, rx_frame_err ← ~stop_sample.
  - If rx_valid is already 1, set rx_overrun. The new byte still overwrites rx_data.
  - Set rx_valid=1.
  - → IDLE if s_in==1. Otherwise → BREAK.
- **BREAK**
  - Wait for s_in==1 → IDLE. This keeps a stuck-low line from being read as back-to-back starts.
- **Handshake**
  - rx_valid clears the cycle after rx_ack==1 is seen while rx_valid==1.
  - rx_ack with rx_valid==0 is ignored.
  - rx_overrun clears only on the same acknowledge.
- **Simultaneous events.** If DONE loads a new byte in the same cycle an ack is seen, the load wins: rx_valid stays 1 with the new data and rx_overrun is set.
- **Reset**, at any time including mid-frame, puts the block in:
  - state IDLE, counters 0, synchronizer flops 1;
  - rx_data=0x00, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0, rx_busy=0.

## Timing
- All outputs are registered.
- Start-edge latency: 2 cycles from the in_serial fall to s_in==0, then 1 cycle to START.
- Sample points, relative to the START entry cycle T:
  - start sample at T+HALF_BIT-1;
  - data bit k (k=0..7) at T+HALF_BIT+(k+1)·CLKS_PER_BIT-1;
  - parity at T+HALF_BIT+9·CLKS_PER_BIT-1;
  - stop at T+HALF_BIT+10·CLKS_PER_BIT-1.
- rx_valid rises one cycle after the stop sample (the DONE cycle's registered outputs).
- Max throughput: one frame per 11·CLKS_PER_BIT cycles. A new start edge is accepted the cycle after DONE.
- Tolerates ±2% clock mismatch against the transmitter at default parameters.

## Test plan
- Frame 0xA5 (line: 0, then 1,0,1,0,0,1,0,1, parity 1, stop 1) at 5209 cycles/bit → rx_valid=1, rx_data=0xA5, parity_err=0, frame_err=0. rx_valid holds until rx_ack, then is 0 the next cycle.
- Frame 0x07 with parity forced to 1 → rx_data=0x07, rx_parity_err=1. Frame 0x00 with parity 1 → rx_parity_err=0.
- Frame 0x3C with the stop bit driven 0 and the line held low for 3 bit times → rx_frame_err=1, state holds in BREAK, no second byte until the line returns high.
- 1000-cycle low glitch on an idle line → back to IDLE after the half-bit sample, rx_valid stays 0, rx_busy pulses for about 2604 cycles.
- Two back-to-back frames 0x11 then 0x22 with no rx_ack → rx_data=0x22, rx_overrun=1. rx_ack clears both rx_valid and rx_overrun.
- rst asserted mid-way through data bit 4 of frame 0xFF → all outputs 0 the next cycle. A following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/u_r_x.sv
// u_r_x: serial receiver for 8-bit data, odd parity, one stop bit.
// The line is synchronized, timed with a bit-period counter and sampled at
// mid-bit. Each received byte is held with a level valid/ack handshake,
// together with parity, framing and sticky overrun status.
module u_r_x #(
   parameter int CLKS_PER_BIT = 5209,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_serial,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BITS,
      S_PAR,
      S_STOP,
      S_DONE,
      S_BREAK
   } state_t;

   localparam logic [12:0] HALF_M1 = 13'(HALF_BIT - 1);
   localparam logic [12:0] FULL_M1 = 13'(CLKS_PER_BIT - 1);

   state_t      state_q;
   logic        sync1_q, sync2_q;
   logic        s_in;
   logic [12:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        par_bad_q;
   logic        stop_q;
   logic        busy_q;

   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        perr_q, perr_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;

   logic        tick_half;
   logic        tick_full;

   assign s_in      = sync2_q;
   assign tick_half = (cnt_q == HALF_M1);
   assign tick_full = (cnt_q == FULL_M1);

   // Two-flop synchronizer for the asynchronous line, idling high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= in_serial;
         sync2_q <= sync1_q;
      end
   end

   // Frame FSM with bit timer, bit counter and sample capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         stop_q    <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         // Free-running timer; wraps to zero each bit period, and is
         // explicitly cleared below on every state change.
         cnt_q <= tick_full ? '0 : cnt_q + 13'd1;
         case (state_q)
            S_IDLE: begin
               if (!s_in) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (tick_half) begin
                  cnt_q <= '0;
                  if (s_in) begin
                     // Line went back high before mid start bit: a glitch.
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_BITS;
                     bit_q   <= '0;
                  end
               end
            end
            S_BITS: begin
               if (tick_full) begin
                  shift_q <= {s_in, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_q <= S_PAR;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end
            end
            S_PAR: begin
               if (tick_full) begin
                  par_bad_q <= ~(^{shift_q, s_in});
                  state_q   <= S_STOP;
               end
            end
            S_STOP: begin
               if (tick_full) begin
                  stop_q  <= s_in;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               cnt_q <= '0;
               if (s_in) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  // A line still low here is a break, not a new start.
                  state_q <= S_BREAK;
               end
            end
            S_BREAK: begin
               if (s_in) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Next-state for the output holding registers: a DONE load beats an ack.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;
      if (state_q == S_DONE) begin
         data_d  = shift_q;
         perr_d  = par_bad_q;
         ferr_d  = ~stop_q;
         valid_d = 1'b1;
         if (valid_q) begin
            ovr_d = 1'b1;
         end
      end else if (rx_ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // Output holding registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign rx_parity_err = perr_q;
   assign rx_frame_err  = ferr_q;
   assign rx_overrun    = ovr_q;
   assign rx_busy       = busy_q;

endmodule

// File: tb/tb_u_r_x.sv
// Testbench for u_r_x: drives serial frames at an exact bit rate and checks
// the received byte and status against a frame-level reference model.
module tb_u_r_x;

   localparam int CPB = 16;
   localparam int HB  = CPB / 2;

   logic       clk;
   logic       rst;
   logic       in_serial;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;

   int n_checks;
   int n_errors;

   // Reference model of the consumer-visible state
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_perr;
   logic       m_ferr;
   logic       m_ovr;

   u_r_x #(
      .CLKS_PER_BIT(CPB),
      .HALF_BIT    (HB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_serial    (in_serial),
      .rx_ack       (rx_ack),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_parity_err(rx_parity_err),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_busy      (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      check($sformatf("%s.valid", tag), 32'(rx_valid), 32'(m_valid));
      check($sformatf("%s.ovr", tag), 32'(rx_overrun), 32'(m_ovr));
      if (m_valid) begin
         check($sformatf("%s.data", tag), 32'(rx_data), 32'(m_data));
         check($sformatf("%s.perr", tag), 32'(rx_parity_err), 32'(m_perr));
         check($sformatf("%s.ferr", tag), 32'(rx_frame_err), 32'(m_ferr));
      end
   endtask

   task automatic drive_bit(input logic b);
      in_serial = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Drives start, 8 data bits LSB first, parity and stop; the line is left
   // at the stop level. Updates the model with the frame it just sent.
   task automatic send_bits(input logic [7:0] d, input logic p, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(stop);
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = d;
      m_perr  = (($countones({d, p}) % 2) == 0);
      m_ferr  = ~stop;
   endtask

   task automatic do_ack();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   initial begin
      int busy_cnt;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      in_serial = 1'b1;
      rx_ack    = 1'b0;
      m_data = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst.data", 32'(rx_data), 32'h0);
      check("rst.valid", 32'(rx_valid), 0);
      check("rst.busy", 32'(rx_busy), 0);
      check("rst.flags", 32'({rx_parity_err, rx_frame_err, rx_overrun}), 0);
      repeat (5) @(negedge clk);

      // Clean frame 0xA5, valid holds until ack
      send_bits(8'hA5, 1'b1, 1'b1);
      check_outs("a5");
      repeat (20) @(negedge clk);
      check("a5.hold", 32'(rx_valid), 1);
      do_ack();
      check_outs("a5.ack");
      do_ack();
      check("ack_idle", 32'(rx_valid), 0);

      // Parity cases
      send_bits(8'h07, 1'b1, 1'b1);
      check_outs("p07");
      do_ack();
      send_bits(8'h00, 1'b1, 1'b1);
      check_outs("p00");
      do_ack();

      // Framing error followed by a held-low break
      send_bits(8'h3C, odd_par(8'h3C), 1'b0);
      check_outs("brk");
      do_ack();
      repeat (3 * CPB) @(negedge clk);
      check("brk.busy", 32'(rx_busy), 1);
      check_outs("brk.low");
      in_serial = 1'b1;
      repeat (6) @(negedge clk);
      check("brk.idle", 32'(rx_busy), 0);
      check_outs("brk.end");

      // Short glitch on an idle line
      busy_cnt  = 0;
      in_serial = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 4) in_serial = 1'b1;
         busy_cnt += int'(rx_busy);
      end
      check("glitch.busy_cycles", 32'(busy_cnt), 32'(HB));
      check_outs("glitch");

      // Back-to-back frames, no ack in between
      send_bits(8'h11, odd_par(8'h11), 1'b1);
      send_bits(8'h22, odd_par(8'h22), 1'b1);
      check_outs("b2b");
      check("b2b.ovr_set", 32'(rx_overrun), 1);
      do_ack();
      check_outs("b2b.ack");

      // Reset in the middle of data bit 4 of 0xFF, with a byte pending
      send_bits(8'h81, odd_par(8'h81), 1'b1);
      repeat (3) @(negedge clk);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      repeat (HB) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_data = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
      check("mrst.data", 32'(rx_data), 0);
      check("mrst.valid", 32'(rx_valid), 0);
      check("mrst.busy", 32'(rx_busy), 0);
      check("mrst.flags", 32'({rx_parity_err, rx_frame_err, rx_overrun}), 0);
      repeat (3 * CPB) @(negedge clk);
      send_bits(8'h5A, odd_par(8'h5A), 1'b1);
      check_outs("post_rst");
      do_ack();

      // Randomized frames
      for (int n = 0; n < 30; n++) begin
         logic [7:0] d;
         logic       p;
         logic       stop;
         d    = 8'($urandom_range(0, 255));
         p    = odd_par(d) ^ ($urandom_range(0, 4) == 0);
         stop = ($urandom_range(0, 5) != 0);
         send_bits(d, p, stop);
         if (!stop) begin
            repeat (1 + $urandom_range(0, 2 * CPB)) @(negedge clk);
            in_serial = 1'b1;
            repeat (4) @(negedge clk);
         end else begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
         end
         check_outs($sformatf("rnd%0d", n));
         if ($urandom_range(0, 3) != 0) begin
            do_ack();
            check_outs($sformatf("rnd%0d.ack", n));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
